dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Sequences the single-port data memory (Rm/Wm/address/RegVal/Data_out) and shares it between the pipeline MEM stage and a DMA/loader port used for program/data preload and debug.
- Sits between the MEM stage and the data memory.
- Owns the memory strobes, enforces the multi-cycle access timing, and stalls the pipeline while the memory is busy.
- The MEM stage has fixed priority; a starvation guard keeps DMA from waiting forever.

Parameters:
ACCESS_CYCLES, 1, cycles mem_rm/mem_wm are held per access (legal 1..15)
STARVE_LIMIT, 4, consecutive CPU grants with dma_req pending before DMA is forced to win (legal 1..15)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_rd  in  1  MEM-stage read request (Rm); held while cpu_stall=1
cpu_wr  in  1  MEM-stage write request (Wm); held while cpu_stall=1
cpu_addr  in  8  MEM-stage address (AC value)
cpu_wdata  in  8  MEM-stage write data (register value)
cpu_rdata  out  8  registered read data to the WB path
cpu_stall  out  1  freeze the pipeline; combinational from request and state
dma_req  in  1  DMA access request, level; held until dma_done
dma_we  in  1  1=write, 0=read; sampled at grant
dma_addr  in  8  DMA address
dma_wdata  in  8  DMA write data
dma_gnt  out  1  high throughout a DMA access
dma_done  out  1  one-cycle pulse after a DMA access completes
dma_rdata  out  8  DMA read data; valid when dma_done=1, then held
mem_rm  out  1  memory read strobe
mem_wm  out  1  memory write strobe
mem_addr  out  8  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data (combinational memory output)

Behaviour:
- Reset (async, immediate): state=IDLE; cnt=0; starve=0. Outputs mem_rm/mem_wm/dma_gnt/dma_done=0, cpu_rdata/dma_rdata/mem_addr/mem_wdata=8'h00. Reset mid-access aborts it; a write may be partial, and the requester reissues.
- cpu_req = cpu_rd | cpu_wr. If both are high, the access is treated as a write and cpu_rdata is not updated.
- States: IDLE, CPU_ACC, DMA_ACC, DMA_FIN.
- IDLE arbitration:
  - If dma_req and starve==STARVE_LIMIT, go to DMA_ACC.
  - Else if cpu_req, go to CPU_ACC.
  - Else if dma_req, go to DMA_ACC.
  - Else stay in IDLE.
  - On the grant edge, address/data/direction are latched into mem_addr/mem_wdata and the strobe register.
- CPU_ACC: mem_rm or mem_wm is high for exactly ACCESS_CYCLES cycles, with cnt counting 0..ACCESS_CYCLES-1.
  - On the edge ending the cycle where cnt==ACCESS_CYCLES-1: a read latches mem_rdata into cpu_rdata, and the state returns to IDLE.
- cpu_stall = cpu_req & ~(state==CPU_ACC & cnt==ACCESS_CYCLES-1).
  - The pipeline advances on the same edge the access completes.
  - Total stall for an uncontended access is ACCESS_CYCLES cycles: the IDLE cycle plus ACCESS_CYCLES-1 strobe cycles.
  - The cycle after completion is IDLE with the next request visible; there is one turnaround cycle between accesses.
- If cpu_req drops mid-access, the access still completes; a write is performed exactly once.
- DMA_ACC: dma_gnt=1 and strobes are timed as in CPU_ACC. On the last cycle, the state goes to DMA_FIN and read data is latched into dma_rdata.
- DMA_FIN: dma_done=1 for one cycle, then IDLE. The requester must drop dma_req or present the next access in that cycle. If dma_req is still high in IDLE, it is a new request.
- If dma_req drops before the grant, no access occurs.
- starve counter:
  - +1, saturating at STARVE_LIMIT, on each CPU grant while dma_req=1.
  - Cleared on a DMA grant, or in any IDLE cycle with dma_req=0.
- mem_addr/mem_wdata hold their last values when idle. Strobes are never both high, and are never high outside CPU_ACC/DMA_ACC.

Decomposition:
- Shared include dmem_defs.vh holds:
  - State encodings: IDLE=2'd0, CPU_ACC=2'd1, DMA_ACC=2'd2, DMA_FIN=2'd3.
  - Default ACCESS_CYCLES and STARVE_LIMIT values.
- One sub-module, access_timer: loadable down/up counter producing the last-cycle flag.
- Arbitration and FSM stay in dmem_arbiter.

Test Plan:
1. ACCESS_CYCLES=1; cpu_wr addr 8'h10 data 8'hA5, then cpu_rd 8'h10 -> mem_wm high 1 cycle, one stall cycle per access, cpu_rdata=8'hA5 after the read edge.
2. ACCESS_CYCLES=3; cpu_rd -> mem_rm high 3 cycles, cpu_stall high 3 cycles then low, cpu_rdata updated on the completion edge.
3. dma_req (write 8'h20=8'h3C) while the CPU issues continuous reads; STARVE_LIMIT=4 -> 4 CPU grants, then dma_gnt; dma_done pulses once; a CPU read of 8'h20 returns 8'h3C.
4. cpu_req and dma_req raised the same cycle with starve=0 -> CPU wins, dma_gnt=0 until CPU completion plus the IDLE cycle.
5. reset_n pulled low during the second cycle of a 3-cycle DMA read -> strobes, dma_gnt and dma_done drop immediately with no clock edge; after release, state=IDLE and cpu_rdata=8'h00.
6. cpu_rd and cpu_wr both high -> a write occurs and cpu_rdata is unchanged; cpu_req dropped mid-write -> exactly one write of ACCESS_CYCLES strobes.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t        : arbiter state encoding (IDLE/CPU_ACC/DMA_ACC/DMA_FIN)
//   DEF_ACCESS_CYCLES  : default strobe length per access
//   DEF_STARVE_LIMIT   : default CPU grants tolerated while DMA waits
//   CNT_W              : width of the access timer and starvation counter
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      DMA_ACC = 2'd2,
      DMA_FIN = 2'd3
   } arb_state_t;

   localparam int unsigned DEF_ACCESS_CYCLES = 1;
   localparam int unsigned DEF_STARVE_LIMIT  = 4;
   localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/dmem_arbiter_timer.sv
// Access timer: down-counter loaded at grant with ACCESS_CYCLES-1, counting
// toward zero while an access runs; terminal count marks the last strobe cycle.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   load           : grant edge, reload the counter
//   run            : an access is in progress
//   last           : counter at terminal count (only meaningful while run=1)
module access_timer
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES
)(
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic run,
   output logic last
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (run && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the MEM
// stage (fixed priority) and a DMA/loader port, owns the memory strobes and
// stalls the pipeline while an access is outstanding.
// Ports:
//   clock, reset_n                       : clock, async active-low reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata     : MEM-stage request (held while stalled)
//   cpu_rdata, cpu_stall                 : registered read data, pipeline freeze
//   dma_req/dma_we/dma_addr/dma_wdata    : DMA request (level, held until done)
//   dma_gnt, dma_done, dma_rdata         : DMA grant, completion pulse, read data
//   mem_rm/mem_wm/mem_addr/mem_wdata     : memory strobes, address, write data
//   mem_rdata                            : combinational memory read data
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no access; arbitrate and latch the winner on this edge
// CPU_ACC | CPU strobe active, timer counting down to the last cycle
// DMA_ACC | DMA strobe active, dma_gnt high
// DMA_FIN | one-cycle dma_done pulse, requester drops or renews dma_req
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
   parameter int unsigned STARVE_LIMIT  = DEF_STARVE_LIMIT
)(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cpu_rd,
   input  logic       cpu_wr,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_stall,
   input  logic       dma_req,
   input  logic       dma_we,
   input  logic [7:0] dma_addr,
   input  logic [7:0] dma_wdata,
   output logic       dma_gnt,
   output logic       dma_done,
   output logic [7:0] dma_rdata,
   output logic       mem_rm,
   output logic       mem_wm,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] starve_q;
   logic             wr_q;
   logic             last;
   logic             in_acc;
   logic             cpu_req;
   logic             grant_cpu, grant_dma;

   assign cpu_req = cpu_rd | cpu_wr;
   assign in_acc  = (state_q == CPU_ACC) || (state_q == DMA_ACC);

   access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (grant_cpu | grant_dma),
      .run     (in_acc),
      .last    (last)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      case (state_q)
         IDLE: begin
            // starvation guard overrides the CPU's fixed priority
            if (dma_req && starve_q == STARVE_MAX) begin
               grant_dma = 1'b1;
               state_d   = DMA_ACC;
            end else if (cpu_req) begin
               grant_cpu = 1'b1;
               state_d   = CPU_ACC;
            end else if (dma_req) begin
               grant_dma = 1'b1;
               state_d   = DMA_ACC;
            end
         end
         CPU_ACC: if (last) state_d = IDLE;
         DMA_ACC: if (last) state_d = DMA_FIN;
         DMA_FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_addr  <= 8'h00;
         mem_wdata <= 8'h00;
         wr_q      <= 1'b0;
         cpu_rdata <= 8'h00;
         dma_rdata <= 8'h00;
         starve_q  <= '0;
      end else begin
         // cpu_wr wins over cpu_rd when both are asserted
         if (grant_cpu) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            wr_q      <= cpu_wr;
         end else if (grant_dma) begin
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
            wr_q      <= dma_we;
         end

         if (state_q == CPU_ACC && last && !wr_q) cpu_rdata <= mem_rdata;
         if (state_q == DMA_ACC && last && !wr_q) dma_rdata <= mem_rdata;

         if (grant_dma) begin
            starve_q <= '0;
         end else if (grant_cpu && dma_req) begin
            if (starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
         end else if (state_q == IDLE && !dma_req) begin
            starve_q <= '0;
         end
      end
   end

   // strobes decode from state so they can never be high outside an access
   assign mem_rm    = in_acc & ~wr_q;
   assign mem_wm    = in_acc &  wr_q;
   assign dma_gnt   = (state_q == DMA_ACC);
   assign dma_done  = (state_q == DMA_FIN);
   assign cpu_stall = cpu_req & ~((state_q == CPU_ACC) & last);

endmodule
